// File: rtl/color_frame_classifier.sv
// color_frame_classifier: classifies RGB565 pixels as red/green/blue/other,
// counts each class over a frame and, one decision per vsync rising edge,
// drives a one-hot colour LED result with the winning count.
// Optional build macro COLOR_HYST_EN: the LEDs only change when two
// consecutive frame decisions agree.
module color_frame_classifier #(
    parameter int R_HI       = 17,
    parameter int R_LO       = 11,
    parameter int G_HI       = 28,
    parameter int G_LO       = 20,
    parameter int B_HI       = 17,
    parameter int B_LO       = 11,
    parameter int CNT_W      = 17,
    parameter int MIN_PIXELS = 1024
) (
    input  logic             p_clock,
    input  logic             rst,
    input  logic [15:0]      pixel_data,
    input  logic             pixel_valid,
    input  logic             vsync,
    input  logic             colr,
    output logic [2:0]       led,
    output logic             result_valid,
    output logic [CNT_W-1:0] dominant_count
);

    typedef enum logic [2:0] {IDLE, SYNC, ACCUM, FLUSH, DECIDE} state_t;

    localparam logic [4:0]       R_HI_V  = 5'(R_HI);
    localparam logic [4:0]       R_LO_V  = 5'(R_LO);
    localparam logic [5:0]       G_HI_V  = 6'(G_HI);
    localparam logic [5:0]       G_LO_V  = 6'(G_LO);
    localparam logic [4:0]       B_HI_V  = 5'(B_HI);
    localparam logic [4:0]       B_LO_V  = 5'(B_LO);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_next;
    logic             vs_d, vs_rise;
    logic [4:0]       r_ch, b_ch;
    logic [5:0]       g_ch;
    logic             is_red, is_green, is_blue, accept;
    logic             s1_valid;
    logic [1:0]       s1_class;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
    logic             cnt_clear;
    logic [CNT_W-1:0] max_cnt;
    logic [2:0]       winner, cand;
    logic             dec_pend;
    logic [2:0]       dec_led;
    logic [CNT_W-1:0] dec_cnt;
`ifdef COLOR_HYST_EN
    logic [2:0]       prev_cand;
`endif

    assign r_ch    = pixel_data[15:11];
    assign g_ch    = pixel_data[10:5];
    assign b_ch    = pixel_data[4:0];
    assign vs_rise = vsync && !vs_d;
    assign accept  = (state == ACCUM) && pixel_valid && !vsync;

    // Pixel class decode; overlaps resolve red first, then green, then blue.
    always_comb begin
        is_red   = (r_ch > R_HI_V) && (g_ch < G_LO_V) && (b_ch < B_LO_V);
        is_green = !is_red && (r_ch < R_LO_V) && (g_ch > G_HI_V) && (b_ch < B_LO_V);
        is_blue  = !is_red && !is_green && (r_ch < R_LO_V) && (g_ch < G_LO_V) && (b_ch > B_HI_V);
    end

    // vsync history used to find the frame boundary.
    always_ff @(posedge p_clock) begin
        if (rst) vs_d <= 1'b0;
        else     vs_d <= vsync;
    end

    // State register.
    always_ff @(posedge p_clock) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Frame sequencing; counters are wiped whenever a fresh count must start.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        if (!colr) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_next = SYNC;
                    cnt_clear  = 1'b1;
                end
                SYNC: if (vs_rise) begin
                    state_next = ACCUM;
                    cnt_clear  = 1'b1;
                end
                ACCUM:  if (vs_rise) state_next = FLUSH;
                FLUSH:  state_next = DECIDE;
                DECIDE: begin
                    state_next = ACCUM;
                    cnt_clear  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Stage 1: capture the class of each accepted, classifiable pixel.
    always_ff @(posedge p_clock) begin
        if (rst || !colr) begin
            s1_valid <= 1'b0;
            s1_class <= 2'd0;
        end else begin
            s1_valid <= accept && (is_red || is_green || is_blue);
            s1_class <= is_red ? 2'd0 : (is_green ? 2'd1 : 2'd2);
        end
    end

    // Stage 2: saturating per-class counters.
    always_ff @(posedge p_clock) begin
        if (rst || cnt_clear) begin
            cnt_r <= '0;
            cnt_g <= '0;
            cnt_b <= '0;
        end else if (s1_valid) begin
            case (s1_class)
                2'd0:    if (cnt_r != CNT_MAX) cnt_r <= cnt_r + 1'b1;
                2'd1:    if (cnt_g != CNT_MAX) cnt_g <= cnt_g + 1'b1;
                2'd2:    if (cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
                default: ;
            endcase
        end
    end

    // Pick the dominant class (ties go red, green, blue) and qualify it.
    always_comb begin
        if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
            max_cnt = cnt_r;
            winner  = 3'b100;
        end else if (cnt_g >= cnt_b) begin
            max_cnt = cnt_g;
            winner  = 3'b010;
        end else begin
            max_cnt = cnt_b;
            winner  = 3'b001;
        end
        cand = (32'(max_cnt) >= 32'(MIN_PIXELS)) ? winner : 3'b111;
    end

    // Latch the frame decision while the counters are being cleared.
    always_ff @(posedge p_clock) begin
        if (rst || !colr) begin
            dec_pend <= 1'b0;
            dec_led  <= 3'b000;
            dec_cnt  <= '0;
        end else begin
            dec_pend <= (state == DECIDE);
            if (state == DECIDE) begin
                dec_led <= cand;
                dec_cnt <= max_cnt;
            end
        end
    end

`ifdef COLOR_HYST_EN
    // Remember the previous frame's candidate so a change needs two agreeing frames.
    always_ff @(posedge p_clock) begin
        if (rst || !colr)  prev_cand <= 3'b000;
        else if (dec_pend) prev_cand <= dec_led;
    end
`endif

    // Publish the decision and strobe result_valid; outputs hold otherwise.
    always_ff @(posedge p_clock) begin
        if (rst) begin
            led            <= 3'b000;
            result_valid   <= 1'b0;
            dominant_count <= '0;
        end else if (!colr) begin
            result_valid <= 1'b0;
        end else begin
            result_valid <= dec_pend;
            if (dec_pend) begin
`ifdef COLOR_HYST_EN
                if (dec_led == prev_cand) begin
                    led            <= dec_led;
                    dominant_count <= dec_cnt;
                end
`else
                led            <= dec_led;
                dominant_count <= dec_cnt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_color_frame_classifier.sv
// Testbench for color_frame_classifier. Three instances (default config,
// MIN_PIXELS=32, CNT_W=4/MIN_PIXELS=8) see the same pixel stream; a frame
// model pushes expected results per frame and they are popped when
// result_valid appears. Follows COLOR_HYST_EN when it is defined.
module tb_color_frame_classifier;

    typedef struct packed {
        logic [2:0][2:0]  led;
        logic [2:0][16:0] cnt;
    } exp_t;

    logic        p_clock = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pixel_data = 16'h0000;
    logic        pixel_valid = 1'b0;
    logic        vsync = 1'b0;
    logic        colr = 1'b0;

    logic [2:0]  led_a, led_b, led_c;
    logic        rv_a, rv_b, rv_c;
    logic [16:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    logic [2:0][2:0]  led_o;
    logic [2:0][16:0] cnt_o;
    logic [2:0]       rv_o;

    int checks = 0;
    int errors = 0;
    int nr = 0, ng = 0, nb = 0;
    exp_t exp_q[$];
    logic [2:0] held_led[3];
    int         held_cnt[3];
    logic [2:0] prev_model[3];

    color_frame_classifier u_dut (
        .p_clock(p_clock), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .vsync(vsync), .colr(colr), .led(led_a), .result_valid(rv_a), .dominant_count(cnt_a)
    );

    color_frame_classifier #(.MIN_PIXELS(32)) u_min32 (
        .p_clock(p_clock), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .vsync(vsync), .colr(colr), .led(led_b), .result_valid(rv_b), .dominant_count(cnt_b)
    );

    color_frame_classifier #(.CNT_W(4), .MIN_PIXELS(8)) u_small (
        .p_clock(p_clock), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .vsync(vsync), .colr(colr), .led(led_c), .result_valid(rv_c), .dominant_count(cnt_c)
    );

    assign led_o[0] = led_a;
    assign led_o[1] = led_b;
    assign led_o[2] = led_c;
    assign cnt_o[0] = cnt_a;
    assign cnt_o[1] = cnt_b;
    assign cnt_o[2] = {13'd0, cnt_c};
    assign rv_o     = {rv_c, rv_b, rv_a};

    // Free-running pixel clock.
    always #5 p_clock = ~p_clock;

    function automatic int cw_of(input int i);
        return (i == 2) ? 4 : 17;
    endfunction

    function automatic int min_of(input int i);
        return (i == 0) ? 1024 : ((i == 1) ? 32 : 8);
    endfunction

    function automatic int sat(input int n, input int w);
        int cap;
        cap = (1 << w) - 1;
        return (n > cap) ? cap : n;
    endfunction

    // Class from the default thresholds: 0 red, 1 green, 2 blue, 3 other.
    function automatic int pix_class(input logic [15:0] d);
        int r, g, b;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        if (r > 17 && g < 20 && b < 11) return 0;
        if (r < 11 && g > 28 && b < 11) return 1;
        if (r < 11 && g < 20 && b > 17) return 2;
        return 3;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            held_led[i]   = 3'b000;
            held_cnt[i]   = 0;
            prev_model[i] = 3'b000;
        end
        exp_q.delete();
        nr = 0;
        ng = 0;
        nb = 0;
    endfunction

    function automatic exp_t model_decide();
        exp_t e;
        int sr, sg, sb, mx;
        logic [2:0] w, cand;
        for (int i = 0; i < 3; i++) begin
            sr = sat(nr, cw_of(i));
            sg = sat(ng, cw_of(i));
            sb = sat(nb, cw_of(i));
            if (sr >= sg && sr >= sb) begin mx = sr; w = 3'b100; end
            else if (sg >= sb)        begin mx = sg; w = 3'b010; end
            else                      begin mx = sb; w = 3'b001; end
            cand = (mx >= min_of(i)) ? w : 3'b111;
`ifdef COLOR_HYST_EN
            if (cand == prev_model[i]) begin
                held_led[i] = cand;
                held_cnt[i] = mx;
            end
            prev_model[i] = cand;
`else
            held_led[i] = cand;
            held_cnt[i] = mx;
`endif
            e.led[i] = held_led[i];
            e.cnt[i] = 17'(held_cnt[i]);
        end
        return e;
    endfunction

    task automatic send_pixels(input logic [15:0] data, input int n, input logic valid);
        for (int j = 0; j < n; j++) begin
            @(negedge p_clock);
            pixel_data  = data;
            pixel_valid = valid;
            vsync       = 1'b0;
            if (valid) begin
                case (pix_class(data))
                    0: nr++;
                    1: ng++;
                    2: nb++;
                    default: ;
                endcase
            end
        end
    endtask

    // Raise vsync; when a decision is due, the result must appear exactly
    // three edges after vsync is first sampled and last a single cycle.
    task automatic end_frame(input bit expect_result, input bit dirty, input string tag);
        exp_t e, got;
        @(negedge p_clock);
        vsync       = 1'b1;
        pixel_valid = dirty;
        pixel_data  = 16'hF800;
        if (expect_result) begin
            e = model_decide();
            exp_q.push_back(e);
        end
        nr = 0;
        ng = 0;
        nb = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge p_clock);
            if (c == 3 && expect_result) begin
                checks++;
                if (rv_o !== 3'b111) begin
                    errors++;
                    $display("[TB] FAIL %s result_valid at k+3: got %b want 111", tag, rv_o);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s scoreboard empty", tag);
                end else begin
                    got = exp_q.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        checks++;
                        if (led_o[i] !== got.led[i]) begin
                            errors++;
                            $display("[TB] FAIL %s inst%0d led: got %b want %b", tag, i, led_o[i], got.led[i]);
                        end
                        checks++;
                        if (cnt_o[i] !== got.cnt[i]) begin
                            errors++;
                            $display("[TB] FAIL %s inst%0d dominant_count: got %0d want %0d", tag, i, cnt_o[i], got.cnt[i]);
                        end
                    end
                end
            end else begin
                checks++;
                if (rv_o !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL %s result_valid at k+%0d: got %b want 000", tag, c, rv_o);
                end
            end
            if (c == 0) pixel_valid = 1'b0;
            if (c == 1) vsync = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge p_clock);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (led_o[i] !== 3'b000 || rv_o[i] !== 1'b0 || cnt_o[i] !== 17'd0) begin
                errors++;
                $display("[TB] FAIL reset inst%0d: got led=%b rv=%b cnt=%0d want 000/0/0", i, led_o[i], rv_o[i], cnt_o[i]);
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_dominant_red();
        @(negedge p_clock);
        colr = 1'b1;
        end_frame(1'b0, 1'b0, "sync");
        send_pixels(16'hF800, 1100, 1'b1);
        send_pixels(16'h07E0, 200, 1'b1);
        end_frame(1'b1, 1'b0, "dominant_red");
    endtask

    task automatic test_min_pixels();
        send_pixels(16'h001F, 500, 1'b1);
        end_frame(1'b1, 1'b0, "below_min");
        send_pixels(16'h001F, 2000, 1'b1);
        end_frame(1'b1, 1'b0, "above_min");
    endtask

    task automatic test_tie_and_qualifiers();
        send_pixels(16'hF800, 25, 1'b1);
        send_pixels(16'hF800, 30, 1'b0);
        send_pixels(16'h07E0, 50, 1'b1);
        send_pixels(16'h1234, 10, 1'b1);
        send_pixels(16'hF800, 25, 1'b1);
        end_frame(1'b1, 1'b1, "tie_qualifiers");
    endtask

    task automatic test_saturation();
        send_pixels(16'h001F, 20, 1'b1);
        end_frame(1'b1, 1'b0, "saturation");
    endtask

    task automatic test_colr_drop();
        send_pixels(16'hF800, 600, 1'b1);
        @(negedge p_clock);
        pixel_valid = 1'b0;
        colr = 1'b0;
        for (int i = 0; i < 3; i++) prev_model[i] = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge p_clock);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rv_o[i] !== 1'b0 || led_o[i] !== held_led[i] || cnt_o[i] !== 17'(held_cnt[i])) begin
                    errors++;
                    $display("[TB] FAIL colr_low inst%0d: got rv=%b led=%b cnt=%0d want 0/%b/%0d",
                             i, rv_o[i], led_o[i], cnt_o[i], held_led[i], held_cnt[i]);
                end
            end
        end
        colr = 1'b1;
        send_pixels(16'h07E0, 40, 1'b1);
        end_frame(1'b0, 1'b0, "colr_resync");
        send_pixels(16'h001F, 40, 1'b1);
        end_frame(1'b1, 1'b0, "after_colr");
    endtask

    task automatic test_hysteresis();
        @(negedge p_clock);
        rst  = 1'b1;
        colr = 1'b0;
        @(negedge p_clock);
        rst = 1'b0;
        model_reset();
        colr = 1'b1;
        end_frame(1'b0, 1'b0, "hyst_sync");
        send_pixels(16'hF800, 20, 1'b1);
        end_frame(1'b1, 1'b0, "hyst_red");
        send_pixels(16'h07E0, 20, 1'b1);
        end_frame(1'b1, 1'b0, "hyst_green1");
        send_pixels(16'h07E0, 20, 1'b1);
        end_frame(1'b1, 1'b0, "hyst_green2");
    endtask

    task automatic test_reset_mid_accum();
        send_pixels(16'hF800, 100, 1'b1);
        @(negedge p_clock);
        rst = 1'b1;
        pixel_valid = 1'b0;
        @(negedge p_clock);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (led_o[i] !== 3'b000 || rv_o[i] !== 1'b0 || cnt_o[i] !== 17'd0) begin
                errors++;
                $display("[TB] FAIL mid_reset inst%0d: got led=%b rv=%b cnt=%0d want 000/0/0", i, led_o[i], rv_o[i], cnt_o[i]);
            end
        end
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge p_clock);
            checks++;
            if (rv_o !== 3'b000) begin
                errors++;
                $display("[TB] FAIL post_reset result_valid: got %b want 000", rv_o);
            end
        end
    endtask

    // Test sequence and summary.
    initial begin
        $display("[TB] color_frame_classifier bench start");
        test_reset();
        test_dominant_red();
        test_min_pixels();
        test_tie_and_qualifiers();
        test_saturation();
        test_colr_drop();
        test_hysteresis();
        test_reset_mid_accum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
